// File: rtl/scan_dr_sequencer.sv
// TMS/TDI master that walks a TAP through one DR scan (select, capture, shift, update) per request.
// Optional build macro SCAN_PARITY_EN adds a running XOR of the captured TDO bits on tdo_parity.
module scan_dr_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               tck,
    input  logic               trst,
    input  logic               start,
    input  logic               reset_tap,
    input  logic [LEN_W-1:0]   scan_len,
    input  logic [MAX_LEN-1:0] tdi_data,
    input  logic               tdo,
    output logic               tms,
    output logic               tdi,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [MAX_LEN-1:0] tdo_data,
    output logic               tdo_parity
);

    typedef enum logic [3:0] {
        ST_INIT  = 4'd0,
        ST_IDLE  = 4'd1,
        ST_RST   = 4'd2,
        ST_SEL   = 4'd3,
        ST_CAP   = 4'd4,
        ST_ENT   = 4'd5,
        ST_SHIFT = 4'd6,
        ST_UPD   = 4'd7,
        ST_RET   = 4'd8
    } state_t;

    localparam logic [LEN_W-1:0] PRE_LAST  = LEN_W'(5);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    state_t             state_r;
    state_t             next_state_s;
    logic [LEN_W-1:0]   count_r;
    logic [LEN_W-1:0]   count_nxt_s;
    logic [LEN_W-1:0]   len_r;
    logic [MAX_LEN-1:0] data_r;
    logic [MAX_LEN-1:0] cap_r;
    logic [MAX_LEN-1:0] tdo_data_r;
    logic               done_r;
    logic               err_r;
    logic               tms_s;
    logic               tdi_s;
    logic               busy_s;
    logic               accept_s;
    logic               reject_s;
    logic               done_nxt_s;
    logic               req_valid_s;

    assign req_valid_s = (scan_len != {LEN_W{1'b0}}) && (scan_len <= MAX_LEN_C);

    // State and bit/preamble counter register.
    always_ff @(posedge tck) begin
        if (trst) begin
            state_r <= ST_INIT;
            count_r <= {LEN_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            count_r <= count_nxt_s;
        end
    end

    // Next-state logic and Moore decode of tms/tdi/busy from state and counter only.
    always_comb begin
        next_state_s = state_r;
        count_nxt_s  = count_r;
        tms_s        = 1'b0;
        tdi_s        = 1'b0;
        busy_s       = 1'b1;
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        done_nxt_s   = 1'b0;
        case (state_r)
            ST_INIT, ST_RST: begin
                // Five TMS=1 cycles reach test_logic_reset from any TAP state; one TMS=0 parks in run_test_idle.
                tms_s = (count_r < PRE_LAST) ? 1'b1 : 1'b0;
                if (count_r == PRE_LAST) begin
                    next_state_s = (state_r == ST_INIT) ? ST_IDLE : ST_SEL;
                    count_nxt_s  = {LEN_W{1'b0}};
                end else begin
                    count_nxt_s  = count_r + LEN_W'(1);
                end
            end
            ST_IDLE: begin
                busy_s = 1'b0;
                if (start) begin
                    if (req_valid_s) begin
                        accept_s     = 1'b1;
                        next_state_s = reset_tap ? ST_RST : ST_SEL;
                        count_nxt_s  = {LEN_W{1'b0}};
                    end else begin
                        reject_s     = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEL: begin
                tms_s        = 1'b1;
                next_state_s = ST_CAP;
            end
            ST_CAP: begin
                next_state_s = ST_ENT;
            end
            ST_ENT: begin
                next_state_s = ST_SHIFT;
                count_nxt_s  = {LEN_W{1'b0}};
            end
            ST_SHIFT: begin
                tdi_s = data_r[0];
                if (count_r == (len_r - LEN_W'(1))) begin
                    tms_s        = 1'b1;
                    next_state_s = ST_UPD;
                    count_nxt_s  = {LEN_W{1'b0}};
                end else begin
                    count_nxt_s  = count_r + LEN_W'(1);
                end
            end
            ST_UPD: begin
                tms_s        = 1'b1;
                next_state_s = ST_RET;
            end
            ST_RET: begin
                next_state_s = ST_IDLE;
                done_nxt_s   = 1'b1;
            end
            default: begin
                tms_s        = 1'b1;
                next_state_s = ST_INIT;
                count_nxt_s  = {LEN_W{1'b0}};
            end
        endcase
    end

    // Request latch, TDI shifter, TDO capture and result/pulse registers.
    always_ff @(posedge tck) begin
        if (trst) begin
            len_r      <= {LEN_W{1'b0}};
            data_r     <= {MAX_LEN{1'b0}};
            cap_r      <= {MAX_LEN{1'b0}};
            tdo_data_r <= {MAX_LEN{1'b0}};
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= done_nxt_s;
            err_r  <= reject_s;
            if (accept_s) begin
                len_r  <= scan_len;
                data_r <= tdi_data;
                // Cleared here so bits at or above scan_len read back as 0.
                cap_r  <= {MAX_LEN{1'b0}};
            end else if (state_r == ST_SHIFT) begin
                data_r <= {1'b0, data_r[MAX_LEN-1:1]};
                for (int j = 0; j < MAX_LEN; j++) begin
                    if (count_r == LEN_W'(j)) begin
                        cap_r[j] <= tdo;
                    end
                end
            end
            if (done_nxt_s) begin
                tdo_data_r <= cap_r;
            end
        end
    end

`ifdef SCAN_PARITY_EN
    logic parity_acc_r;
    logic tdo_parity_r;

    function automatic logic parity_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    // Running parity of sampled TDO bits, published together with tdo_data.
    always_ff @(posedge tck) begin
        if (trst) begin
            parity_acc_r <= 1'b0;
            tdo_parity_r <= 1'b0;
        end else begin
            if (accept_s) begin
                parity_acc_r <= 1'b0;
            end else if (state_r == ST_SHIFT) begin
                parity_acc_r <= parity_step(parity_acc_r, tdo);
            end
            if (done_nxt_s) begin
                tdo_parity_r <= parity_acc_r;
            end
        end
    end

    assign tdo_parity = tdo_parity_r;
`else
    assign tdo_parity = 1'b0;
`endif

    assign tms      = tms_s;
    assign tdi      = tdi_s;
    assign busy     = busy_s;
    assign done     = done_r;
    assign err      = err_r;
    assign tdo_data = tdo_data_r;

endmodule

// File: tb/tb_scan_dr_sequencer.sv
// Randomized bench for scan_dr_sequencer: an IEEE 1149.1 TAP model answers the DUT, scans are predicted from their parameters.
module tb_scan_dr_sequencer;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    localparam int TLR = 0, RTI = 1, SDS = 2, CDR = 3, SDR = 4, E1D = 5, PDR = 6, E2D = 7;
    localparam int UDR = 8, SIS = 9, CIR = 10, SIR = 11, E1I = 12, PIR = 13, E2I = 14, UIR = 15;

    logic               tck = 1'b0;
    logic               trst, start, reset_tap, tdo;
    logic [LEN_W-1:0]   scan_len;
    logic [MAX_LEN-1:0] tdi_data;
    logic               tms, tdi, busy, done, err, tdo_parity;
    logic [MAX_LEN-1:0] tdo_data;

    int n_checks = 0;
    int n_errors = 0;

    int          tap;
    bit          tms_smp = 1'b1;
    bit          tdi_smp = 1'b0;
    logic [31:0] cap_word = 32'd0;
    logic [31:0] got_word = 32'd0;
    logic [4:0]  sh_idx   = 5'd0;
    int          n_shift  = 0;
    int          upd_cnt  = 0;
    logic [31:0] last_tdo = 32'd0;
    logic        last_par = 1'b0;

    scan_dr_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .tck(tck), .trst(trst), .start(start), .reset_tap(reset_tap),
        .scan_len(scan_len), .tdi_data(tdi_data), .tdo(tdo),
        .tms(tms), .tdi(tdi), .busy(busy), .done(done), .err(err),
        .tdo_data(tdo_data), .tdo_parity(tdo_parity)
    );

    always #5 tck = ~tck;

    function automatic int tap_next(input int s, input bit t);
        case (s)
            TLR: return t ? TLR : RTI;
            RTI: return t ? SDS : RTI;
            SDS: return t ? SIS : CDR;
            CDR: return t ? E1D : SDR;
            SDR: return t ? E1D : SDR;
            E1D: return t ? UDR : PDR;
            PDR: return t ? E2D : PDR;
            E2D: return t ? UDR : SDR;
            UDR: return t ? SDS : RTI;
            SIS: return t ? TLR : CIR;
            CIR: return t ? E1I : SIR;
            SIR: return t ? E1I : SIR;
            E1I: return t ? UIR : PIR;
            PIR: return t ? E2I : PIR;
            E2I: return t ? UIR : SIR;
            UIR: return t ? SDS : RTI;
            default: return TLR;
        endcase
    endfunction

    function automatic logic [31:0] len_mask(input int len);
        if (len >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << len) - 32'd1;
    endfunction

    // TAP drives tdo mid-cycle: DR bit while shifting, junk otherwise.
    always @(negedge tck) begin
        tms_smp = tms;
        tdi_smp = tdi;
        if (tap == SDR) tdo = cap_word[sh_idx];
        else            tdo = 1'($urandom);
    end

    // TAP state machine and DR shift on the rising edge.
    always @(posedge tck) begin
        if (tap == CDR) begin
            sh_idx = 5'd0; n_shift = 0; got_word = 32'd0;
        end else if (tap == SDR) begin
            got_word[sh_idx] = tdi_smp;
            sh_idx = sh_idx + 5'd1;
            n_shift++;
        end else if (tap == UDR) begin
            upd_cnt++;
        end
        tap = tap_next(tap, tms_smp);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    // Six-cycle preamble seen from the first cycle after reset release.
    task automatic init_seq();
        for (int k = 0; k < 6; k++) begin
            check_val("init_tms", 64'(tms), 64'(k < 5));
            check_val("init_busy", 64'(busy), 64'd1);
            check_val("init_done", 64'(done), 64'd0);
            check_val("init_tdi", 64'(tdi), 64'd0);
            step();
        end
        check_val("init_idle_busy", 64'(busy), 64'd0);
        check_val("init_idle_tms", 64'(tms), 64'd0);
        check_val("init_tap_rti", 64'(tap), 64'(RTI));
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            check_val("idle_busy", 64'(busy), 64'd0);
            check_val("idle_tms", 64'(tms), 64'd0);
            check_val("idle_tdi", 64'(tdi), 64'd0);
            check_val("idle_done", 64'(done), 64'd0);
            check_val("idle_err", 64'(err), 64'd0);
            check_val("idle_tdo_data", 64'(tdo_data), 64'(last_tdo));
        end
    endtask

    task automatic bad_request(input logic [LEN_W-1:0] len);
        start = 1'b1; scan_len = len; tdi_data = 32'($urandom); reset_tap = 1'($urandom);
        step();
        start = 1'b0;
        check_val("bad_err", 64'(err), 64'd1);
        check_val("bad_busy", 64'(busy), 64'd0);
        check_val("bad_tms", 64'(tms), 64'd0);
        check_val("bad_tdo_data", 64'(tdo_data), 64'(last_tdo));
        step();
        check_val("bad_err_clear", 64'(err), 64'd0);
        check_val("bad_busy2", 64'(busy), 64'd0);
        check_val("bad_tms2", 64'(tms), 64'd0);
    endtask

    // One scan, starting from a cycle where the DUT is idle (possibly its done cycle).
    task automatic do_scan(input int len, input logic [31:0] data, input logic rtap, input logic [31:0] cap);
        bit          exp_tms[$];
        bit          exp_tdi[$];
        int          total;
        logic [31:0] exp_d;
        logic        exp_par;
        check_val("pre_busy", 64'(busy), 64'd0);
        cap_word = cap;
        upd_cnt  = 0;
        start = 1'b1; scan_len = LEN_W'(len); tdi_data = data; reset_tap = rtap;
        if (rtap) begin
            for (int i = 0; i < 6; i++) begin
                exp_tms.push_back(i < 5); exp_tdi.push_back(1'b0);
            end
        end
        exp_tms.push_back(1'b1); exp_tms.push_back(1'b0); exp_tms.push_back(1'b0);
        for (int i = 0; i < 3; i++) exp_tdi.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            exp_tms.push_back(i == len - 1);
            exp_tdi.push_back(bit'((data >> i) & 32'd1));
        end
        exp_tms.push_back(1'b1); exp_tms.push_back(1'b0);
        exp_tdi.push_back(1'b0); exp_tdi.push_back(1'b0);
        total = len + 5 + (rtap ? 6 : 0);
        step();
        start = 1'b0; scan_len = LEN_W'($urandom); tdi_data = 32'($urandom); reset_tap = 1'($urandom);
        for (int k = 0; k < total; k++) begin
            check_val("scan_busy", 64'(busy), 64'd1);
            check_val("scan_done", 64'(done), 64'd0);
            check_val("scan_err", 64'(err), 64'd0);
            check_val("scan_tms", 64'(tms), 64'(exp_tms[k]));
            check_val("scan_tdi", 64'(tdi), 64'(exp_tdi[k]));
            check_val("scan_tdo_hold", 64'(tdo_data), 64'(last_tdo));
            if (k < total - 1 && $urandom_range(0, 3) == 0) begin
                start = 1'b1; scan_len = LEN_W'($urandom_range(0, 63));
            end
            step();
            start = 1'b0;
        end
        exp_d = cap & len_mask(len);
`ifdef SCAN_PARITY_EN
        exp_par = ^exp_d;
`else
        exp_par = 1'b0;
`endif
        check_val("end_done", 64'(done), 64'd1);
        check_val("end_busy", 64'(busy), 64'd0);
        check_val("end_err", 64'(err), 64'd0);
        check_val("end_tms", 64'(tms), 64'd0);
        check_val("end_tdo_data", 64'(tdo_data), 64'(exp_d));
        check_val("end_parity", 64'(tdo_parity), 64'(exp_par));
        check_val("end_tap_rti", 64'(tap), 64'(RTI));
        check_val("end_shift_count", 64'(n_shift), 64'(len));
        check_val("end_tap_tdi", 64'(got_word & len_mask(len)), 64'(data & len_mask(len)));
        check_val("end_update", 64'(upd_cnt), 64'd1);
        last_tdo = exp_d;
        last_par = exp_par;
    endtask

    initial begin
        tap = $urandom_range(0, 15);
        trst = 1'b1; start = 1'b0; reset_tap = 1'b0; scan_len = '0; tdi_data = '0; tdo = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("rst_tms", 64'(tms), 64'd1);
            check_val("rst_tdi", 64'(tdi), 64'd0);
            check_val("rst_busy", 64'(busy), 64'd1);
            check_val("rst_done", 64'(done), 64'd0);
            check_val("rst_err", 64'(err), 64'd0);
            check_val("rst_tdo_data", 64'(tdo_data), 64'd0);
            check_val("rst_parity", 64'(tdo_parity), 64'd0);
        end
        trst = 1'b0;
        init_seq();
        idle_cycles(2);

        do_scan(8, 32'h0000_00A5, 1'b0, 32'h0000_003C);
        idle_cycles(1);
        bad_request(6'd0);
        bad_request(6'd33);
        bad_request(6'($urandom_range(33, 63)));
        do_scan(1, 32'($urandom), 1'b1, 32'($urandom));
        do_scan(4, 32'($urandom), 1'b0, 32'($urandom));
        do_scan(4, 32'($urandom), 1'b0, 32'($urandom));
        do_scan(32, 32'($urandom), 1'b0, 32'($urandom));
        idle_cycles(1);

        for (int n = 0; n < 40; n++) begin
            do_scan($urandom_range(1, 32), 32'($urandom), 1'($urandom), 32'($urandom));
            idle_cycles($urandom_range(0, 2));
        end

        // Make sure there is something to clear, then abort a 16-bit scan at bit 3.
        do_scan(5, 32'($urandom), 1'b0, 32'h0000_0015);
        idle_cycles(1);
        start = 1'b1; scan_len = 6'd16; tdi_data = 32'($urandom); reset_tap = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        trst = 1'b1;
        step();
        check_val("abort_tms", 64'(tms), 64'd1);
        check_val("abort_tdo_data", 64'(tdo_data), 64'd0);
        check_val("abort_done", 64'(done), 64'd0);
        check_val("abort_busy", 64'(busy), 64'd1);
        check_val("abort_parity", 64'(tdo_parity), 64'd0);
        trst = 1'b0;
        last_tdo = 32'd0;
        init_seq();
        idle_cycles(2);
        do_scan(3, 32'($urandom), 1'b0, 32'($urandom));
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
